// File: rtl/lot_status_display.sv
// rtl/lot_status_display.sv - occupancy count to six-digit 7-seg board with CLEAR/FULL text
module lot_status_display #(
    parameter int WIDTH     = 8,
    parameter int CAPACITY  = 25,
    parameter int NDIGITS   = 2,
    parameter int BLINK_EN  = 1,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    // Decimal digits needed to hold 2^WIDTH-1 (floor(WIDTH*log10(2))+1).
    localparam int BCDN = (WIDTH * 30103) / 100000 + 1;
    localparam int BW   = 4 * BCDN;
    localparam int CW   = $clog2(WIDTH);
    localparam int BCW  = $clog2(BLINK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    localparam logic [6:0] BLANK = 7'h7F;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int MAXV = pow10(NDIGITS) - 1;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = BLANK;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [5:0][6:0]  dig_q, dig_d;
    logic [BCW-1:0]   blink_q;
    logic             phase_q;

    logic [BW-1:0]    bcd_adj;
    logic [5:0][6:0]  dig_new;
    logic [5:0][6:0]  hex_c;

    // Add-3 correction on every BCD nibble ahead of the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < BCDN; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Finished conversion to glyphs: saturate, then blank leading zeros above HEX0.
    always_comb begin
        logic        sat;
        logic        nz;
        logic [3:0]  d;
        logic [23:0] bcd_ext;
        sat     = 64'(last_q) > 64'(MAXV);
        nz      = 1'b0;
        d       = 4'd0;
        bcd_ext = 24'(bcd_q);
        dig_new = {6{BLANK}};
        for (int i = 5; i >= 0; i--) begin
            if (i < NDIGITS) begin
                d = sat ? 4'd9 : bcd_ext[4*i +: 4];
                if (d != 4'd0) nz = 1'b1;
                dig_new[i] = (nz || i == 0) ? glyph(d) : BLANK;
            end
        end
    end

    // Conversion sequencer: capture, WIDTH shift-add-3 steps, then one atomic display load.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        last_d    = last_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        full_d    = full_q;
        empty_d   = empty_q;
        dig_d     = dig_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q || count != last_q) begin
                    sh_d      = count;
                    last_d    = count;
                    pending_d = 1'b0;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = {bcd_adj[BW-2:0], sh_q[WIDTH-1]};
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                dig_d   = dig_new;
                full_d  = 64'(last_q) >= 64'(CAPACITY);
                empty_d = last_q == '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Conversion state registers; reset leaves a forced conversion pending.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b1;
            last_q    <= '0;
            sh_q      <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b0;
            dig_q     <= {6{BLANK}};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            sh_q      <= sh_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            dig_q     <= dig_d;
        end
    end

    // Free-running blink divider; phase 1 means FULL text hidden.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_q <= '0;
            phase_q <= 1'b0;
        end else if (blink_q == BCW'(BLINK_DIV - 1)) begin
            blink_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    // Text overlay on top of the digit registers; CLEAR wins over FULL.
    always_comb begin
        hex_c = dig_q;
        if (NDIGITS <= 2) begin
            if (empty_q) begin
                hex_c[5] = 7'h46;
                hex_c[4] = 7'h47;
                hex_c[3] = 7'h06;
                hex_c[2] = 7'h08;
                hex_c[1] = 7'h2F;
            end else if (full_q && !(BLINK_EN != 0 && phase_q)) begin
                hex_c[5] = 7'h0E;
                hex_c[4] = 7'h41;
                hex_c[3] = 7'h47;
                hex_c[2] = 7'h47;
            end
        end
    end

    assign busy  = busy_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign HEX0  = hex_c[0];
    assign HEX1  = hex_c[1];
    assign HEX2  = hex_c[2];
    assign HEX3  = hex_c[3];
    assign HEX4  = hex_c[4];
    assign HEX5  = hex_c[5];

endmodule

// File: tb/tb_lot_status_display.sv
// tb/tb_lot_status_display.sv - randomized model-checked bench for lot_status_display
module tb_lot_status_display;

    localparam int W   = 8;
    localparam int CAP = 25;
    localparam int BD  = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] count = '0;

    logic       a_busy, a_full, a_empty;
    logic [6:0] a0, a1, a2, a3, a4, a5;
    logic       b_busy, b_full, b_empty;
    logic [6:0] b0, b1, b2, b3, b4, b5;

    lot_status_display #(.WIDTH(W), .CAPACITY(CAP), .NDIGITS(2), .BLINK_EN(1), .BLINK_DIV(BD)) u_two (
        .clk(clk), .reset_n(reset_n), .count(count),
        .busy(a_busy), .full(a_full), .empty(a_empty),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5)
    );

    lot_status_display #(.WIDTH(W), .CAPACITY(CAP), .NDIGITS(3), .BLINK_EN(1), .BLINK_DIV(BD)) u_three (
        .clk(clk), .reset_n(reset_n), .count(count),
        .busy(b_busy), .full(b_full), .empty(b_empty),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    // Behavioural model: value shown on the board, plus the time left until a captured value appears.
    int m_shown   = -1;
    int m_last    = 0;
    int m_val     = 0;
    int m_timer   = 0;
    int m_bc      = 0;
    bit m_pending = 1'b1;
    bit m_busy    = 1'b0;
    bit m_phase   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_shown = -1; m_pending = 1'b1; m_busy = 1'b0; m_timer = 0;
                m_last = 0; m_bc = 0; m_phase = 1'b0;
            end else begin
                if (m_bc == BD - 1) begin m_bc = 0; m_phase = ~m_phase; end
                else m_bc++;
                if (m_timer > 0) begin
                    m_timer--;
                    if (m_timer == 0) begin m_shown = m_val; m_busy = 1'b0; end
                end else if (m_pending || int'(count) != m_last) begin
                    m_val = int'(count); m_last = int'(count);
                    m_pending = 1'b0; m_busy = 1'b1; m_timer = W + 1;
                end
            end
        end
    end

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
            5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    function automatic logic [41:0] exp_hex(input int shown, input int nd, input bit ph);
        logic [5:0][6:0] h;
        int pw, v, p;
        h = {6{7'h7F}};
        if (shown < 0) return h;
        pw = 1;
        for (int i = 0; i < nd; i++) pw *= 10;
        v = (shown > pw - 1) ? pw - 1 : shown;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            if (i == 0 || v >= p) h[i] = seg((v / p) % 10);
            p *= 10;
        end
        if (nd <= 2) begin
            if (shown == 0) begin
                h[5] = 7'h46; h[4] = 7'h47; h[3] = 7'h06; h[2] = 7'h08; h[1] = 7'h2F;
            end else if (shown >= CAP && !ph) begin
                h[5] = 7'h0E; h[4] = 7'h41; h[3] = 7'h47; h[2] = 7'h47;
            end
        end
        return h;
    endfunction

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("two_hex", {a5, a4, a3, a2, a1, a0}, exp_hex(m_shown, 2, m_phase));
                chk("two_busy", a_busy, m_busy);
                chk("two_full", a_full, m_shown >= CAP);
                chk("two_empty", a_empty, m_shown == 0);
                chk("three_hex", {b5, b4, b3, b2, b1, b0}, exp_hex(m_shown, 3, m_phase));
                chk("three_busy", b_busy, m_busy);
                chk("three_full", b_full, m_shown >= CAP);
                chk("three_empty", b_empty, m_shown == 0);
            end
        end
    end

    int vis;

    initial begin
        reset_n = 1'b0;
        count   = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("lit_reset_hex", {a5, a4, a3, a2, a1, a0}, {6{7'h7F}});
        chk("lit_reset_busy", a_busy, 1'b0);

        reset_n = 1'b1;
        @(negedge clk);
        chk("lit_busy_rise", a_busy, 1'b1);
        repeat (8) @(negedge clk);
        chk("lit_busy_hold", {a_busy, a0}, {1'b1, 7'h7F});
        @(negedge clk);
        chk("lit_clear", {a5, a4, a3, a2, a1, a0}, {7'h46, 7'h47, 7'h06, 7'h08, 7'h2F, 7'h40});
        chk("lit_clear_flags", {a_empty, a_full, a_busy}, 3'b100);

        count = 8'd7;
        repeat (9) @(negedge clk);
        chk("lit_seven_early", a0, 7'h40);
        @(negedge clk);
        chk("lit_seven", {a5, a4, a3, a2, a1, a0}, {{5{7'h7F}}, 7'h78});
        chk("lit_seven_empty", a_empty, 1'b0);

        count = 8'd25;
        repeat (10) @(negedge clk);
        chk("lit_25_digits", {a1, a0, a_full}, {7'h24, 7'h12, 1'b1});
        vis = 0;
        repeat (8) begin
            @(negedge clk);
            if (a5 == 7'h0E) vis++;
            chk("lit_25_full", a_full, 1'b1);
        end
        chk("lit_blink_visible", vis, 4);

        count = 8'd150;
        repeat (10) @(negedge clk);
        chk("lit_150_sat", {a1, a0, a_full}, {7'h10, 7'h10, 1'b1});
        chk("lit_150_three", {b5, b4, b3, b2, b1, b0}, {{3{7'h7F}}, 7'h79, 7'h12, 7'h40});

        count = 8'd12;
        repeat (4) @(negedge clk);
        count = 8'd13;
        repeat (6) @(negedge clk);
        chk("lit_12_shown", {a1, a0}, {7'h79, 7'h24});
        repeat (9) @(negedge clk);
        chk("lit_12_held", {a1, a0}, {7'h79, 7'h24});
        @(negedge clk);
        chk("lit_13_shown", {a1, a0}, {7'h79, 7'h30});

        count = 8'd99;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("lit_abort", {a_busy, a5, a4, a3, a2, a1, a0}, {1'b0, {6{7'h7F}}});
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("lit_after_abort", {a1, a0, a_full}, {7'h10, 7'h10, 1'b1});

        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) count = W'($urandom_range(0, 30));
            else if (r < 7) count = W'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset_n = 1'b1;
            end
            repeat ($urandom_range(1, 14)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
